// File: rtl/tft_spi_tx_if.sv
// tft_spi_tx_if: drawer-to-transmitter byte handshake (tft_transmit strobe, tft_dc, tft_data in; tft_busy back)
interface tft_spi_tx_if;
  logic       tft_transmit;
  logic       tft_dc;
  logic [7:0] tft_data;
  logic       tft_busy;
  modport master (output tft_transmit, tft_dc, tft_data, input tft_busy);
  modport slave (input tft_transmit, tft_dc, tft_data, output tft_busy);
endinterface

// File: rtl/tft_spi_tx.sv
// tft_spi_tx: panel reset/wake sequencer plus MSB-first SPI mode-0 byte sender; ports clk, rst, bus (byte handshake), spi_sck/spi_mosi/spi_cs/spi_dc, lcd_rst_n
module tft_spi_tx #(
  parameter int CLK_DIV      = 2,
  parameter int RESET_CYCLES = 1000,
  parameter int WAKE_CYCLES  = 12000,
  parameter int CS_HOLD      = 8
) (
  input  logic               clk,
  input  logic               rst,
  tft_spi_tx_if.slave        bus,
  output logic               spi_sck,
  output logic               spi_mosi,
  output logic               spi_cs,
  output logic               spi_dc,
  output logic               lcd_rst_n
);
  localparam int M1 = RESET_CYCLES > WAKE_CYCLES ? RESET_CYCLES : WAKE_CYCLES;
  localparam int M2 = CS_HOLD > CLK_DIV ? CS_HOLD : CLK_DIV;
  localparam int CW = $clog2((M1 > M2 ? M1 : M2) + 1);
  typedef enum logic [2:0] {RST_HOLD, RST_WAIT, IDLE, SHIFT, HOLD} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic busy_q, busy_d, sck_q, sck_d, mosi_q, mosi_d, cs_q, cs_d, dc_q, dc_d, rstn_q, rstn_d;
  logic load;
  assign load = (state_q == IDLE || state_q == HOLD) && bus.tft_transmit;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    busy_d  = busy_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    cs_d    = cs_q;
    dc_d    = dc_q;
    rstn_d  = rstn_q;
    case (state_q)
      RST_HOLD: if (cnt_q == CW'(RESET_CYCLES - 1)) begin
        rstn_d  = 1'b1;
        cnt_d   = '0;
        state_d = RST_WAIT;
      end
      RST_WAIT: if (cnt_q == CW'(WAKE_CYCLES - 1)) begin
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      IDLE: cnt_d = '0;
      SHIFT: if (cnt_q == CW'(CLK_DIV - 1)) begin
        cnt_d = '0;
        sck_d = ~sck_q;
        if (sck_q && bit_q == 3'd0) begin
          busy_d  = 1'b0;
          state_d = HOLD;
        end else if (sck_q) begin
          bit_d  = bit_q - 3'd1;
          mosi_d = sh_q[bit_d];
        end
      end
      HOLD: if (cnt_q == CW'(CS_HOLD - 1)) begin
        cs_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = RST_HOLD;
    endcase
    if (load) begin
      state_d = SHIFT;
      cnt_d   = '0;
      bit_d   = 3'd7;
      sh_d    = bus.tft_data;
      mosi_d  = bus.tft_data[7];
      dc_d    = bus.tft_dc;
      cs_d    = 1'b0;
      busy_d  = 1'b1;
      sck_d   = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_HOLD;
      cnt_q   <= '0;
      bit_q   <= 3'd7;
      sh_q    <= '0;
      busy_q  <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
      dc_q    <= 1'b0;
      rstn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      busy_q  <= busy_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      cs_q    <= cs_d;
      dc_q    <= dc_d;
      rstn_q  <= rstn_d;
    end
  end
  assign bus.tft_busy = busy_q;
  assign spi_sck      = sck_q;
  assign spi_mosi     = mosi_q;
  assign spi_cs       = cs_q;
  assign spi_dc       = dc_q;
  assign lcd_rst_n    = rstn_q;
endmodule

// File: tb/tb_tft_spi_tx.sv
// tb_tft_spi_tx: directed self-checking bench for tft_spi_tx with CLK_DIV=2, RESET_CYCLES=4, WAKE_CYCLES=6, CS_HOLD=8
module tb_tft_spi_tx;
  logic clk = 1'b0;
  logic rst;
  logic spi_sck, spi_mosi, spi_cs, spi_dc, lcd_rst_n;
  tft_spi_tx_if bus ();
  tft_spi_tx #(.CLK_DIV(2), .RESET_CYCLES(4), .WAKE_CYCLES(6), .CS_HOLD(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_cs(spi_cs), .spi_dc(spi_dc), .lcd_rst_n(lcd_rst_n)
  );
  always #5 clk = ~clk;
  int compared = 0;
  int mism = 0;
  int cyc = 0;
  int rises = 0;
  int cs_rises = 0;
  int dc_bad = 0;
  int mosi_bad = 0;
  int rt [64];
  logic [15:0] bits = '0;
  logic [15:0] dcs = '0;
  logic sck_p = 1'b0, cs_p = 1'b1, dc_p = 1'b0, mosi_p = 1'b0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (spi_sck && !sck_p) begin
      rt[rises[5:0]] <= cyc;
      bits <= {bits[14:0], spi_mosi};
      dcs <= {dcs[14:0], spi_dc};
      rises <= rises + 1;
    end
    if (spi_cs && !cs_p) cs_rises <= cs_rises + 1;
    if (spi_sck && sck_p && spi_dc != dc_p) dc_bad <= dc_bad + 1;
    if (spi_sck && spi_mosi != mosi_p) mosi_bad <= mosi_bad + 1;
    sck_p <= spi_sck;
    cs_p <= spi_cs;
    dc_p <= spi_dc;
    mosi_p <= spi_mosi;
  end
  task automatic step;
    @(negedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_busy_low(input string tag);
    int n = 0;
    while (bus.tft_busy && n < 200) begin
      step;
      n++;
    end
    chk(tag, {31'd0, bus.tft_busy}, 0);
  endtask
  task automatic wait_cs_high(input string tag);
    int n = 0;
    while (!spi_cs && n < 200) begin
      step;
      n++;
    end
    chk(tag, {31'd0, spi_cs}, 1);
  endtask
  task automatic strobe(input logic dc, input logic [7:0] d);
    bus.tft_transmit = 1'b1;
    bus.tft_dc = dc;
    bus.tft_data = d;
    step;
    bus.tft_transmit = 1'b0;
  endtask
  initial begin
    int r0, cr, nb, nc, ok, n;
    rst = 1'b1;
    bus.tft_transmit = 1'b0;
    bus.tft_dc = 1'b0;
    bus.tft_data = 8'h00;
    step;
    step;
    rst = 1'b0;
    chk("rst_busy", {31'd0, bus.tft_busy}, 1);
    chk("rst_sck", {31'd0, spi_sck}, 0);
    chk("rst_mosi", {31'd0, spi_mosi}, 0);
    chk("rst_cs", {31'd0, spi_cs}, 1);
    chk("rst_dc", {31'd0, spi_dc}, 0);
    r0 = rises;
    bus.tft_transmit = 1'b1;
    bus.tft_data = 8'hA5;
    ok = 1;
    for (int i = 0; i < 4; i++) begin
      if (lcd_rst_n !== 1'b0 || bus.tft_busy !== 1'b1 || spi_cs !== 1'b1) ok = 0;
      step;
    end
    chk("rst_hold_window", ok, 1);
    chk("lcd_rst_n_rise", {31'd0, lcd_rst_n}, 1);
    ok = 1;
    for (int i = 0; i < 6; i++) begin
      if (lcd_rst_n !== 1'b1 || bus.tft_busy !== 1'b1 || spi_cs !== 1'b1) ok = 0;
      step;
    end
    bus.tft_transmit = 1'b0;
    chk("wake_window", ok, 1);
    chk("wake_busy_fall", {31'd0, bus.tft_busy}, 0);
    step;
    step;
    chk("reset_no_sck", rises - r0, 0);
    chk("reset_cs_idle", {31'd0, spi_cs}, 1);
    r0 = rises;
    strobe(1'b0, 8'h2A);
    chk("cmd_cs", {31'd0, spi_cs}, 0);
    chk("cmd_dc", {31'd0, spi_dc}, 0);
    chk("cmd_busy", {31'd0, bus.tft_busy}, 1);
    chk("cmd_sck", {31'd0, spi_sck}, 0);
    chk("cmd_mosi7", {31'd0, spi_mosi}, 0);
    nb = 0;
    while (bus.tft_busy && nb < 100) begin
      nb++;
      step;
    end
    chk("cmd_busy_len", nb, 32);
    chk("cmd_rises", rises - r0, 8);
    chk("cmd_bits", {24'd0, bits[7:0]}, 32'h2A);
    ok = 1;
    for (int k = 0; k < 7; k++) if (rt[r0 + k + 1] - rt[r0 + k] != 4) ok = 0;
    chk("cmd_rise_spacing", ok, 1);
    nc = 0;
    while (!spi_cs && nc < 100) begin
      nc++;
      step;
    end
    chk("cmd_cs_hold", nc, 8);
    r0 = rises;
    cr = cs_rises;
    strobe(1'b1, 8'hFF);
    wait_busy_low("b2b_first_timeout");
    strobe(1'b1, 8'h00);
    chk("b2b_cs_low", {31'd0, spi_cs}, 0);
    chk("b2b_busy", {31'd0, bus.tft_busy}, 1);
    wait_busy_low("b2b_second_timeout");
    chk("b2b_rises", rises - r0, 16);
    chk("b2b_bits", {16'd0, bits}, 32'hFF00);
    chk("b2b_dc", {16'd0, dcs}, 32'hFFFF);
    chk("b2b_no_cs_glitch", cs_rises - cr, 0);
    wait_cs_high("b2b_cs_release");
    r0 = rises;
    cr = cs_rises;
    strobe(1'b1, 8'h3C);
    wait_busy_low("exp_first_timeout");
    for (int i = 0; i < 7; i++) step;
    chk("exp_cs_still_low", {31'd0, spi_cs}, 0);
    strobe(1'b0, 8'hC3);
    chk("exp_load_cs", {31'd0, spi_cs}, 0);
    chk("exp_load_busy", {31'd0, bus.tft_busy}, 1);
    chk("exp_load_dc", {31'd0, spi_dc}, 0);
    chk("exp_load_mosi", {31'd0, spi_mosi}, 1);
    wait_busy_low("exp_second_timeout");
    chk("exp_no_cs_rise", cs_rises - cr, 0);
    chk("exp_rises", rises - r0, 16);
    chk("exp_bits", {16'd0, bits}, 32'h3CC3);
    wait_cs_high("exp_cs_release");
    r0 = rises;
    strobe(1'b1, 8'h96);
    for (int i = 0; i < 10; i++) step;
    bus.tft_transmit = 1'b1;
    bus.tft_dc = 1'b0;
    bus.tft_data = 8'h55;
    for (int i = 0; i < 3; i++) step;
    bus.tft_transmit = 1'b0;
    wait_busy_low("ign_timeout");
    chk("ign_bits", {24'd0, bits[7:0]}, 32'h96);
    chk("ign_dc", {24'd0, dcs[7:0]}, 32'hFF);
    wait_cs_high("ign_cs_release");
    for (int i = 0; i < 40; i++) step;
    chk("ign_no_extra", rises - r0, 8);
    chk("ign_idle_busy", {31'd0, bus.tft_busy}, 0);
    r0 = rises;
    strobe(1'b1, 8'hA5);
    n = 0;
    while (rises - r0 < 3 && n < 100) begin
      step;
      n++;
    end
    chk("mid_third_rise", rises - r0, 3);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("mid_cs", {31'd0, spi_cs}, 1);
    chk("mid_sck", {31'd0, spi_sck}, 0);
    chk("mid_lcd_rst_n", {31'd0, lcd_rst_n}, 0);
    chk("mid_busy", {31'd0, bus.tft_busy}, 1);
    r0 = rises;
    for (int i = 0; i < 10; i++) step;
    chk("mid_no_sck", rises - r0, 0);
    chk("mid_reseq_busy", {31'd0, bus.tft_busy}, 0);
    chk("mid_reseq_lcd", {31'd0, lcd_rst_n}, 1);
    strobe(1'b0, 8'h81);
    wait_busy_low("rec_timeout");
    chk("rec_bits", {24'd0, bits[7:0]}, 32'h81);
    chk("rec_rises", rises - r0, 8);
    wait_cs_high("rec_cs_release");
    chk("dc_stable_sck_high", dc_bad, 0);
    chk("mosi_stable_sck_high", mosi_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
